// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the memory-stage data-bus controller:
// access kinds, dbus request/response bundles, encode helpers.
package common;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB, LBU, LH, LHU, LW,
    SB, SH, SW
  } mem_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd1,
    MSIZE2 = 3'd2,
    MSIZE4 = 3'd4
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  function automatic logic is_load(mem_t m);
    logic r;
    r = 1'b0;
    case (m)
      LB, LBU, LH, LHU, LW: r = 1'b1;
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(mem_t m);
    logic r;
    r = 1'b0;
    case (m)
      SB, SH, SW: r = 1'b1;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(
    mem_t m, logic [1:0] off
  );
    logic r;
    r = 1'b0;
    case (m)
      LH, LHU, SH: r = off[0];
      LW, SW:      r = (off != 2'b00);
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic msize_t size_of(mem_t m);
    msize_t r;
    r = MSIZE1;
    case (m)
      LH, LHU, SH: r = MSIZE2;
      LW, SW:      r = MSIZE4;
      default:     r = MSIZE1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] strobe_of(
    mem_t m, logic [1:0] off
  );
    logic [3:0] r;
    r = 4'b0000;
    case (m)
      SB:      r = 4'b0001 << off;
      SH:      r = 4'b0011 << {off[1], 1'b0};
      SW:      r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Replicate right-aligned store data into every lane
  // so the strobe alone picks the bytes written.
  function automatic logic [31:0] lanes_of(
    mem_t m, logic [31:0] w
  );
    logic [31:0] r;
    r = w;
    case (m)
      SB:      r = {4{w[7:0]}};
      SH:      r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic dbus_req_t build_req(
    mem_t m, logic [31:0] a, logic [31:0] w
  );
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = a;
    r.size   = size_of(m);
    r.strobe = strobe_of(m, a[1:0]);
    r.data   = lanes_of(m, w);
    return r;
  endfunction

endpackage

// File: rtl/dmem_ctrl_load_extend.sv
// Load lane select and sign/zero extension.
// Ports: mtype/off (latched at issue), raw bus data in, data out.
module load_extend
  import common::*;
(
  input  mem_t        mtype,
  input  logic [1:0]  off,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = raw[7:0];
    case (off)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
  end

  assign h = off[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    data = raw;
    case (mtype)
      LB:      data = {{24{b[7]}}, b};
      LBU:     data = {24'd0, b};
      LH:      data = {{16{h[15]}}, h};
      LHU:     data = {16'd0, h};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage dbus controller: alignment check, single
// request per instruction, stall, flush drain, load result.
// Ports: clk/resetn, in_valid/mem_type/addr/wdata, advance,
// flush; stall, rdata, adel/ades, dreq out, dresp in.
module dmem_ctrl
  import common::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  mem_t        mem_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        advance,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  state;
  logic [2:0]  nxt;
  dbus_req_t   req_q;
  mem_t        mtype_q;
  logic        killed;
  logic        kill_n;
  logic [31:0] rdata_q;

  logic        mis;
  logic        start;
  logic        pend;
  logic        aok;
  logic        dok;
  logic        cap;
  logic        cap_ld;
  mem_t        cur_type;
  logic [1:0]  cur_off;
  logic [31:0] ext_data;
  dbus_req_t   new_req;

  assign mis = misaligned(mem_type, addr[1:0]);
  assign aok = dresp.addr_ok;
  assign dok = dresp.data_ok;

  // Outputs are forced low while reset is held,
  // independent of what the pipeline presents.
  assign adel = resetn & in_valid
              & is_load(mem_type) & mis;
  assign ades = resetn & in_valid
              & is_store(mem_type) & mis;

  assign start = resetn & (state == S_IDLE)
               & in_valid & (mem_type != NONE)
               & ~mis & ~flush;

  // A flush seen in REQ is remembered until the
  // request is accepted, since valid cannot drop.
  assign pend = killed | flush;

  assign new_req = build_req(mem_type, addr, wdata);

  always_comb begin
    dreq = '0;
    if (resetn) begin
      if (state == S_REQ)
        dreq = req_q;
      else if (start)
        dreq = new_req;
    end
  end

  always_comb begin
    stall = 1'b0;
    if (resetn) begin
      stall = ((start
              | (state == S_REQ)
              | (state == S_WAIT)
              | (state == S_DRAIN)) & ~flush)
            | ((state == S_DRAIN) & in_valid);
    end
  end

  // In IDLE the access is being issued this cycle,
  // so the extender sees the live inputs.
  assign cur_type = (state == S_IDLE) ? mem_type
                                      : mtype_q;
  assign cur_off  = (state == S_IDLE) ? addr[1:0]
                                      : req_q.addr[1:0];

  load_extend u_ext (
    .mtype (cur_type),
    .off   (cur_off),
    .raw   (dresp.data),
    .data  (ext_data)
  );

  always_comb begin
    nxt    = state;
    cap    = 1'b0;
    kill_n = killed;
    unique case (state)
      S_IDLE: begin
        kill_n = 1'b0;
        if (start) begin
          if (aok & dok) begin
            nxt = S_DONE;
            cap = 1'b1;
          end else if (aok) begin
            nxt = S_WAIT;
          end else begin
            nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        kill_n = pend;
        if (aok & dok) begin
          nxt    = pend ? S_IDLE : S_DONE;
          cap    = ~pend;
          kill_n = 1'b0;
        end else if (aok) begin
          nxt    = pend ? S_DRAIN : S_WAIT;
          kill_n = 1'b0;
        end
      end
      S_WAIT: begin
        if (dok) begin
          nxt = flush ? S_IDLE : S_DONE;
          cap = ~flush;
        end else if (flush) begin
          nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        if (advance | flush)
          nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (dok)
          nxt = S_IDLE;
      end
      default: begin
        nxt    = S_IDLE;
        kill_n = 1'b0;
      end
    endcase
  end

  // Stores also see data_ok; only loads update rdata.
  assign cap_ld = cap & is_load(cur_type);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      killed  <= 1'b0;
      req_q   <= '0;
      mtype_q <= NONE;
      rdata_q <= 32'd0;
    end else begin
      state  <= nxt;
      killed <= kill_n;
      if (start) begin
        req_q   <= new_req;
        mtype_q <= mem_type;
      end
      if (cap_ld)
        rdata_q <= ext_data;
    end
  end

  assign rdata = rdata_q;

endmodule
